// File: rtl/instr_queue.sv
//------------------------------------------------------------------------------
// instr_queue
//
// Circular instruction FIFO between the decode stage and dispatch. Each entry
// holds one decoded control word and its rvfi word. Decode enqueues using the
// ld_iq/iq_ack handshake, dispatch dequeues the oldest entry using
// iq_valid/dispatch_ready, and a mispredict flush discards every entry.
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst             asynchronous active-low reset
//   flush_ip        mispredict flush; empties the queue at the next edge
//   ld_iq           decode requests an enqueue, held until iq_ack
//   cw_in           control word to enqueue
//   rvfi_in         rvfi word to enqueue
//   iq_ack          enqueue accepted this cycle (combinational)
//   iq_valid        head entry is available to dispatch
//   cw_out          head control word
//   rvfi_out        head rvfi word
//   dispatch_ready  dispatch consumes the head this cycle when iq_valid
//   full            occupancy equals DEPTH
//   empty           occupancy is zero
//   count           current occupancy
//------------------------------------------------------------------------------
module instr_queue #(
    parameter int DEPTH  = 8,
    parameter int CW_W   = 128,
    parameter int RVFI_W = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_ip,
    input  logic                     ld_iq,
    input  logic [CW_W-1:0]          cw_in,
    input  logic [RVFI_W-1:0]        rvfi_in,
    output logic                     iq_ack,
    output logic                     iq_valid,
    output logic [CW_W-1:0]          cw_out,
    output logic [RVFI_W-1:0]        rvfi_out,
    input  logic                     dispatch_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Pointers and occupancy
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // Entry storage; contents are never reset, only the pointers are
    logic [CW_W-1:0]   r_cw_mem   [DEPTH];
    logic [RVFI_W-1:0] r_rvfi_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_enq;
    logic w_deq;

    // full/empty come from the occupancy counter so that head==tail is never
    // ambiguous when the pointers wrap.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Decode samples the ack in the same cycle it raises ld_iq, so the ack
    // must be combinational. A full queue refuses even if dispatch frees a
    // slot this cycle; decode simply retries next cycle.
    assign iq_ack   = ld_iq & ~w_full & ~flush_ip;
    assign iq_valid = ~w_empty & ~flush_ip;

    assign w_enq = iq_ack;
    assign w_deq = iq_valid & dispatch_ready;

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign cw_out   = r_cw_mem[r_head];
    assign rvfi_out = r_rvfi_mem[r_head];

    //--------------------------------------------------------------------------
    // Storage write port
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_cw_mem[r_tail]   <= cw_in;
            r_rvfi_mem[r_tail] <= rvfi_in;
        end
    end

    //--------------------------------------------------------------------------
    // Pointer and occupancy control
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_ip) begin
            // w_enq/w_deq are already gated off by flush_ip; the queue is
            // simply emptied and restarted at index 0.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Protocol checks
    //--------------------------------------------------------------------------
    // Remembers that decode was left waiting (request raised, not acked, no
    // flush) so that a withdrawn request can be flagged next cycle.
    logic r_ld_wait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_wait <= 1'b0;
        end else begin
            r_ld_wait <= ld_iq & ~iq_ack & ~flush_ip;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0)
                else $error("instr_queue: DEPTH must be a power of 2 and >= 2");
            assert (r_count <= FULL_CNT)
                else $error("instr_queue: occupancy exceeds DEPTH");
            assert (!(w_deq && w_empty))
                else $error("instr_queue: dequeue while empty");
            assert (!(w_enq && w_full))
                else $error("instr_queue: enqueue while full");
            assert (!(r_ld_wait && !ld_iq && !flush_ip))
                else $warning("instr_queue: ld_iq dropped before iq_ack");
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

    localparam int DEPTH  = 8;
    localparam int CW_W   = 128;
    localparam int RVFI_W = 256;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_ip;
    logic              ld_iq;
    logic [CW_W-1:0]   cw_in;
    logic [RVFI_W-1:0] rvfi_in;
    logic              iq_ack;
    logic              iq_valid;
    logic [CW_W-1:0]   cw_out;
    logic [RVFI_W-1:0] rvfi_out;
    logic              dispatch_ready;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    int tests_run = 0;
    int tests_failed = 0;
    int n_disp = 0;

    typedef struct packed {
        logic [CW_W-1:0]   cw;
        logic [RVFI_W-1:0] rvfi;
    } entry_t;

    entry_t exp_q[$];

    instr_queue #(.DEPTH(DEPTH), .CW_W(CW_W), .RVFI_W(RVFI_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_ip       (flush_ip),
        .ld_iq          (ld_iq),
        .cw_in          (cw_in),
        .rvfi_in        (rvfi_in),
        .iq_ack         (iq_ack),
        .iq_valid       (iq_valid),
        .cw_out         (cw_out),
        .rvfi_out       (rvfi_out),
        .dispatch_ready (dispatch_ready),
        .full           (full),
        .empty          (empty),
        .count          (count)
    );

    always #5 clk = ~clk;

    // The rvfi word is derived from the control word so both halves of every
    // entry are independently checkable.
    function automatic logic [RVFI_W-1:0] mk_rvfi(input logic [CW_W-1:0] cw);
        return {cw ^ 128'h5a5a_0000_ffff_1234_0f0f_a5a5_c3c3_7e7e, ~cw};
    endfunction

    task automatic check(input string name, input logic [RVFI_W-1:0] act,
                         input logic [RVFI_W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic check_state(input string name, input int exp_cnt,
                               input logic exp_valid);
        check({name, ".count"}, RVFI_W'(count), RVFI_W'(exp_cnt));
        check({name, ".iq_valid"}, RVFI_W'(iq_valid), RVFI_W'(exp_valid));
        check({name, ".empty"}, RVFI_W'(empty), RVFI_W'(exp_cnt == 0));
        check({name, ".full"}, RVFI_W'(full), RVFI_W'(exp_cnt == DEPTH));
    endtask

    // One clock cycle of stimulus. Inputs are driven just after a rising edge;
    // the handshake is checked on the falling edge, and the expected entry is
    // pushed to the scoreboard when the bench expects an ack.
    task automatic cyc(input logic ld, input logic [CW_W-1:0] cw, input logic dr,
                       input logic fl, input logic exp_ack);
        ld_iq          = ld;
        cw_in          = cw;
        rvfi_in        = mk_rvfi(cw);
        dispatch_ready = dr;
        flush_ip       = fl;
        @(negedge clk);
        if (ld) check($sformatf("ack cw=%0h", cw), RVFI_W'(iq_ack), RVFI_W'(exp_ack));
        if (fl) begin
            check("flush.iq_valid", RVFI_W'(iq_valid), '0);
            exp_q.delete();
        end
        if (exp_ack) exp_q.push_back('{cw: cw, rvfi: mk_rvfi(cw)});
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever the DUT presents a head that dispatch will take at the
    // next edge, compare it against the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && iq_valid === 1'b1 && dispatch_ready === 1'b1) begin
            n_disp++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL dispatch: got cw %0h expected no entry", cw_out);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("dispatch.cw", RVFI_W'(cw_out), RVFI_W'(e.cw));
                check("dispatch.rvfi", rvfi_out, e.rvfi);
            end
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst = 1'b0; flush_ip = 1'b0; ld_iq = 1'b0; dispatch_ready = 1'b0;
        cw_in = '0; rvfi_in = '0;

        // ---------------- Reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 1'b0);
        check("reset.iq_ack", RVFI_W'(iq_ack), '0);
        rst = 1'b1;

        // ---------------- Three enqueues ----------------
        for (int i = 1; i <= 3; i++) cyc(1'b1, CW_W'(i), 1'b0, 1'b0, 1'b1);
        check_state("enq3", 3, 1'b1);
        check("enq3.cw_out", RVFI_W'(cw_out), RVFI_W'(1));

        // ---------------- Fill, refuse while full, retry ----------------
        for (int i = 4; i <= 8; i++) cyc(1'b1, CW_W'(i), 1'b0, 1'b0, 1'b1);
        check_state("fill", 8, 1'b1);
        cyc(1'b1, CW_W'(9), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, CW_W'(9), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, CW_W'(9), 1'b1, 1'b0, 1'b0);   // dispatch frees a slot, no pass-through
        check_state("full_deq", 7, 1'b1);
        cyc(1'b1, CW_W'(9), 1'b0, 1'b0, 1'b1);
        check_state("refill", 8, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_state("drain", 0, 1'b0);

        // ---------------- Continuous enqueue + dispatch, wrapping ----------------
        d0 = n_disp;
        cyc(1'b1, CW_W'(0), 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 20; i++) begin
            cyc(1'b1, CW_W'(i), 1'b1, 1'b0, 1'b1);
            check($sformatf("stream.count[%0d]", i), RVFI_W'(count), RVFI_W'(1));
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("stream.dispatched", RVFI_W'(n_disp - d0), RVFI_W'(20));
        check_state("stream_end", 0, 1'b0);

        // ---------------- Flush with 5 entries held ----------------
        for (int i = 0; i < 5; i++) cyc(1'b1, CW_W'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        check_state("pre_flush", 5, 1'b1);
        d0 = n_disp;
        cyc(1'b1, CW_W'(8'h99), 1'b1, 1'b1, 1'b0);
        check_state("post_flush", 0, 1'b0);
        check("flush.no_dispatch", RVFI_W'(n_disp - d0), '0);
        cyc(1'b1, CW_W'(8'h98), 1'b1, 1'b1, 1'b0);
        cyc(1'b1, CW_W'(8'h98), 1'b1, 1'b1, 1'b0);
        check_state("multi_flush", 0, 1'b0);
        cyc(1'b1, CW_W'(8'h77), 1'b0, 1'b0, 1'b1);
        check("flush.idx0_cw", RVFI_W'(cw_out), RVFI_W'(8'h77));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_state("flush_drain", 0, 1'b0);

        // ---------------- Asynchronous reset mid-cycle ----------------
        for (int i = 0; i < 4; i++) cyc(1'b1, CW_W'(8'h50 + i), 1'b0, 1'b0, 1'b1);
        check_state("pre_rst", 4, 1'b1);
        ld_iq = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_state("async_rst", 0, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, CW_W'(8'h60), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, CW_W'(8'h61), 1'b0, 1'b0, 1'b1);
        check("rst.first_cw", RVFI_W'(cw_out), RVFI_W'(8'h60));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_state("rst_drain", 0, 1'b0);

        // ---------------- No empty bypass ----------------
        ld_iq = 1'b1; cw_in = CW_W'(8'hA); rvfi_in = mk_rvfi(CW_W'(8'hA));
        dispatch_ready = 1'b1; flush_ip = 1'b0;
        @(negedge clk);
        check("bypass.valid_N", RVFI_W'(iq_valid), '0);
        check("bypass.ack_N", RVFI_W'(iq_ack), RVFI_W'(1));
        exp_q.push_back('{cw: CW_W'(8'hA), rvfi: mk_rvfi(CW_W'(8'hA))});
        @(posedge clk);
        #1;
        ld_iq = 1'b0;
        check("bypass.valid_N1", RVFI_W'(iq_valid), RVFI_W'(1));
        check("bypass.cw_N1", RVFI_W'(cw_out), RVFI_W'(8'hA));
        @(posedge clk);
        #1;
        dispatch_ready = 1'b0;
        check_state("bypass_end", 0, 1'b0);

        check("scoreboard.leftover", RVFI_W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
